output_link_rx: RTL and testbench

Receive-side monitor for the matrix output link. It is driven by the same pins the output stage drives: the N-channel SPI data bus plus the 74HC595-style column-select shift chain. It rebuilds the per-channel bytes and the latched column pattern in the `clk` domain. It sits on the FPGA as a loopback checker for the output path and as the template for the matrix-side decoder.

---
 rtl/output_link_rx.sv | 190 +++++++++++++++++++
 tb/tb_output_link_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_link_rx.sv
// output_link_rx: loopback monitor that rebuilds SPI lane words and the latched column pattern from the output-stage pins.
// Optional build macro OUTPUT_LINK_RX_TIMEOUT_EN adds an idle timeout that discards partial words and pulses frame_error.
module output_link_rx #(
    parameter int CHANNEL_NUMBER = 3,
    parameter int SPI_SIZE       = 8,
    parameter int MSB_FIRST      = 1,
    parameter int COLUMN_BITS    = 17,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 spi_clk,
    input  logic [CHANNEL_NUMBER-1:0]            spi_mosi,
    input  logic                                 ser_clk,
    input  logic                                 ser_data,
    input  logic                                 ser_stcp,
    input  logic                                 ser_n_enable,
    output logic [CHANNEL_NUMBER*SPI_SIZE-1:0]   data_out,
    output logic                                 data_valid,
    output logic                                 frame_error,
    output logic [COLUMN_BITS-1:0]               column_pattern,
    output logic                                 column_strobe,
    output logic                                 column_onehot,
    output logic [$clog2(COLUMN_BITS)-1:0]       column_index,
    output logic                                 outputs_enabled,
    output logic [7:0]                           words_in_column
);
    localparam int CN = CHANNEL_NUMBER;
    localparam int CW = $clog2(SPI_SIZE) + 1;
    localparam int IW = $clog2(COLUMN_BITS);
    localparam int LW = COLUMN_BITS - 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(SPI_SIZE);

    typedef enum logic [2:0] {IDLE = 3'd0, SHIFT = 3'd1, DONE = 3'd2} state_t;

    logic [CN+4:0]           pin_raw, sync_a, sync_b;
    logic [CN-1:0]           mosi_s;
    logic                    spi_clk_s, ser_clk_s, ser_data_s, stcp_s;
    logic [2:0]              clk_prev, rise;
    logic                    spi_rise, ser_rise, stcp_rise;
    state_t                  state, state_nx;
    logic [CN*SPI_SIZE-1:0]  sr, sr_nx, sr_shift;
    logic [CW-1:0]           bit_cnt, cnt_nx;
    logic                    load, timeout;
    logic [COLUMN_BITS-1:0]  chain;
    logic [LW-1:0]           low;
    logic                    onehot_nx;
    logic [IW-1:0]           index_nx;

    // The enable pin is inverted before synchronising so that a cleared synchroniser reads as "outputs disabled".
    assign pin_raw    = {~ser_n_enable, ser_stcp, ser_data, ser_clk, spi_clk, spi_mosi};
    assign mosi_s     = sync_b[CN-1:0];
    assign spi_clk_s  = sync_b[CN];
    assign ser_clk_s  = sync_b[CN+1];
    assign ser_data_s = sync_b[CN+2];
    assign stcp_s     = sync_b[CN+3];
    assign outputs_enabled = sync_b[CN+4];
    assign {stcp_rise, ser_rise, spi_rise} = rise;

    // Two-flop synchroniser for every pin input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= pin_raw;
            sync_b <= sync_a;
        end
    end

    // Registered rising-edge detectors for the three pin clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_prev <= '0;
            rise     <= '0;
        end else begin
            clk_prev <= {stcp_s, ser_clk_s, spi_clk_s};
            rise     <= {stcp_s, ser_clk_s, spi_clk_s} & ~clk_prev;
        end
    end

    for (genvar i = 0; i < CN; i++) begin : g_lane
        assign sr_shift[i*SPI_SIZE +: SPI_SIZE] = (MSB_FIRST != 0)
            ? {sr[i*SPI_SIZE +: SPI_SIZE-1], mosi_s[i]}
            : {mosi_s[i], sr[i*SPI_SIZE+1 +: SPI_SIZE-1]};
    end

`ifdef OUTPUT_LINK_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    assign timeout = (state == SHIFT) && !spi_rise && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Idle counter: counts SHIFT cycles without a spi_clk rise; a rise or a timeout restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt    <= '0;
            frame_error <= 1'b0;
        end else begin
            idle_cnt    <= (state == SHIFT && !spi_rise && !timeout) ? idle_cnt + TW'(1) : '0;
            frame_error <= timeout;
        end
    end
`else
    assign timeout     = 1'b0;
    assign frame_error = 1'b0;
`endif

    // SPI word FSM: next state, shift register and bit counter.
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = bit_cnt;
        load     = 1'b0;
        if (state == IDLE && spi_rise) begin
            sr_nx    = sr_shift;
            cnt_nx   = CNT_ONE;
            state_nx = (CNT_ONE == CNT_FULL) ? DONE : SHIFT;
        end else if (state == SHIFT && spi_rise) begin
            sr_nx    = sr_shift;
            cnt_nx   = bit_cnt + CNT_ONE;
            state_nx = (bit_cnt + CNT_ONE == CNT_FULL) ? DONE : SHIFT;
        end else if (state == SHIFT && timeout) begin
            sr_nx    = '0;
            cnt_nx   = '0;
            state_nx = IDLE;
        end else if (state == DONE) begin
            load     = 1'b1;
            state_nx = IDLE;
        end else if (state != IDLE && state != SHIFT) begin
            state_nx = IDLE;
        end
    end

    // SPI FSM state, shift register and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nx;
            sr      <= sr_nx;
            bit_cnt <= cnt_nx;
        end
    end

    // Word output: publish on DONE; a column latch clears the word count and beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out        <= '0;
            data_valid      <= 1'b0;
            words_in_column <= '0;
        end else begin
            data_valid      <= load;
            data_out        <= load ? sr : data_out;
            words_in_column <= stcp_rise ? 8'd0
                             : (load && words_in_column != 8'hFF) ? words_in_column + 8'd1
                             : words_in_column;
        end
    end

    assign low = chain[LW-1:0];

    // Column decode of the chain contents that are about to be latched.
    always_comb begin
        onehot_nx = (low != '0) && ((low & (low - LW'(1))) == '0);
        index_nx  = '0;
        for (int i = COLUMN_BITS - 1; i >= 0; i--)
            if (chain[i]) index_nx = IW'(i);
    end

    // Shift chain and storage latch; a same-cycle shift and latch stores the pre-shift contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain          <= '0;
            column_pattern <= '0;
            column_strobe  <= 1'b0;
            column_onehot  <= 1'b0;
            column_index   <= '0;
        end else begin
            chain          <= ser_rise ? {chain[COLUMN_BITS-2:0], ser_data_s} : chain;
            column_strobe  <= stcp_rise;
            column_pattern <= stcp_rise ? chain : column_pattern;
            column_onehot  <= stcp_rise ? onehot_nx : column_onehot;
            column_index   <= stcp_rise ? index_nx : column_index;
        end
    end
endmodule

// File: tb/tb_output_link_rx.sv
// tb_output_link_rx: directed table-driven bench for output_link_rx (MSB-first and LSB-first instances on shared pins).
module tb_output_link_rx;
    localparam int CN = 3;

    logic clk = 1'b0, rst = 1'b0, spi_clk = 1'b0;
    logic ser_clk = 1'b0, ser_data = 1'b0, ser_stcp = 1'b0, ser_n_enable = 1'b1;
    logic [CN-1:0] spi_mosi = '0;

    logic [23:0] data_out, l_data_out;
    logic        data_valid, frame_error, column_strobe, column_onehot, outputs_enabled;
    logic        l_data_valid, l_frame_error, l_column_strobe, l_column_onehot, l_outputs_enabled;
    logic [16:0] column_pattern, l_column_pattern;
    logic [4:0]  column_index, l_column_index;
    logic [7:0]  words_in_column, l_words_in_column;

    output_link_rx dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .ser_clk(ser_clk), .ser_data(ser_data), .ser_stcp(ser_stcp), .ser_n_enable(ser_n_enable),
        .data_out(data_out), .data_valid(data_valid), .frame_error(frame_error),
        .column_pattern(column_pattern), .column_strobe(column_strobe), .column_onehot(column_onehot),
        .column_index(column_index), .outputs_enabled(outputs_enabled), .words_in_column(words_in_column)
    );

    output_link_rx #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .ser_clk(ser_clk), .ser_data(ser_data), .ser_stcp(ser_stcp), .ser_n_enable(ser_n_enable),
        .data_out(l_data_out), .data_valid(l_data_valid), .frame_error(l_frame_error),
        .column_pattern(l_column_pattern), .column_strobe(l_column_strobe), .column_onehot(l_column_onehot),
        .column_index(l_column_index), .outputs_enabled(l_outputs_enabled), .words_in_column(l_words_in_column)
    );

    always #5 clk = ~clk;

    int dv_cnt = 0, ldv_cnt = 0, fe_cnt = 0, cs_cnt = 0;
    always @(posedge clk) begin
        if (data_valid) dv_cnt++;
        if (l_data_valid) ldv_cnt++;
        if (frame_error) fe_cnt++;
        if (column_strobe) cs_cnt++;
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [23:0] w, input int hi, input int lo);
        for (int b = hi; b >= lo; b--) begin
            for (int l = 0; l < CN; l++) spi_mosi[l] = w[l*8+b];
            tick(4);
            spi_clk = 1'b1;
            tick(4);
            spi_clk = 1'b0;
        end
        tick(8);
    endtask

    task automatic shift_bit(input logic b);
        ser_data = b;
        tick(4);
        ser_clk = 1'b1;
        tick(4);
        ser_clk = 1'b0;
    endtask

    task automatic pulse_stcp();
        tick(4);
        ser_stcp = 1'b1;
        tick(4);
        ser_stcp = 1'b0;
        tick(4);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_frame_error"}, frame_error, 0);
        check({tag, "_column_pattern"}, column_pattern, 0);
        check({tag, "_column_strobe"}, column_strobe, 0);
        check({tag, "_column_onehot"}, column_onehot, 0);
        check({tag, "_column_index"}, column_index, 0);
        check({tag, "_outputs_enabled"}, outputs_enabled, 0);
        check({tag, "_words_in_column"}, words_in_column, 0);
    endtask

    typedef struct {
        logic [23:0] words;
        logic [23:0] exp_msb;
        logic [23:0] exp_lsb;
        logic [7:0]  exp_wic;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int d0, l0, f0, c0;
        vecs[0] = '{24'hA53CFF, 24'hA53CFF, 24'hA53CFF, 8'd1};
        vecs[1] = '{24'h00FF01, 24'h00FF01, 24'h00FF80, 8'd2};
        vecs[2] = '{24'h123456, 24'h123456, 24'h482C6A, 8'd3};
        vecs[3] = '{24'h000080, 24'h000080, 24'h000001, 8'd4};

        tick(3);
        check_zero("reset");
        rst = 1'b1;
        tick(3);

        for (int i = 0; i < 4; i++) begin
            d0 = dv_cnt;
            l0 = ldv_cnt;
            send_bits(vecs[i].words, 7, 0);
            check("vec_valid_pulses", dv_cnt - d0, 1);
            check("vec_lsb_valid_pulses", ldv_cnt - l0, 1);
            check("vec_data_msb", data_out, vecs[i].exp_msb);
            check("vec_data_lsb", l_data_out, vecs[i].exp_lsb);
            check("vec_words_in_column", words_in_column, vecs[i].exp_wic);
        end

        ser_n_enable = 1'b0;
        tick(1);
        check("oe_after_1", outputs_enabled, 0);
        tick(1);
        check("oe_after_2", outputs_enabled, 1);
        ser_n_enable = 1'b1;
        tick(2);
        check("oe_off", outputs_enabled, 0);

        c0 = cs_cnt;
        shift_bit(1'b1);
        for (int i = 0; i < 16; i++) shift_bit(1'b0);
        pulse_stcp();
        check("col_strobe_pulses", cs_cnt - c0, 1);
        check("col_pattern_top", column_pattern, 17'h10000);
        check("col_onehot_top", column_onehot, 0);
        check("col_index_top", column_index, 16);
        check("col_wic_cleared", words_in_column, 0);
        shift_bit(1'b1);
        pulse_stcp();
        check("col_pattern_bit0", column_pattern, 17'h00001);
        check("col_onehot_bit0", column_onehot, 1);
        check("col_index_bit0", column_index, 0);
        shift_bit(1'b1);
        pulse_stcp();
        check("col_pattern_two", column_pattern, 17'h00003);
        check("col_onehot_two", column_onehot, 0);
        shift_bit(1'b1);
        ser_data = 1'b0;
        tick(4);
        ser_clk = 1'b1;
        ser_stcp = 1'b1;
        tick(4);
        ser_clk = 1'b0;
        ser_stcp = 1'b0;
        tick(6);
        check("col_simul_preshift", column_pattern, 17'h00007);
        check("col_simul_index", column_index, 0);
        pulse_stcp();
        check("col_simul_after", column_pattern, 17'h0000E);
        check("col_simul_index_after", column_index, 1);

        d0 = dv_cnt;
        c0 = cs_cnt;
        send_bits(24'h0F0F0F, 7, 0);
        check("coin_wic_before", words_in_column, 1);
        send_bits(24'hC3C3C3, 7, 1);
        for (int l = 0; l < CN; l++) spi_mosi[l] = 1'b1;
        tick(4);
        spi_clk = 1'b1;
        tick(1);
        ser_stcp = 1'b1;
        tick(3);
        spi_clk = 1'b0;
        tick(1);
        ser_stcp = 1'b0;
        tick(10);
        check("coin_valid_pulses", dv_cnt - d0, 2);
        check("coin_strobe_pulses", cs_cnt - c0, 1);
        check("coin_data", data_out, 24'hC3C3C3);
        check("coin_wic_cleared", words_in_column, 0);

        d0 = dv_cnt;
        f0 = fe_cnt;
        send_bits(24'h818181, 7, 3);
        tick(80);
        check("partial_no_valid", dv_cnt - d0, 0);
`ifdef OUTPUT_LINK_RX_TIMEOUT_EN
        check("timeout_error_pulses", fe_cnt - f0, 1);
        send_bits(24'h818181, 7, 0);
`else
        check("no_timeout_error", fe_cnt - f0, 0);
        send_bits(24'h818181, 2, 0);
`endif
        check("after_partial_valid", dv_cnt - d0, 1);
        check("after_partial_data", data_out, 24'h818181);

        ser_n_enable = 1'b0;
        d0 = dv_cnt;
        f0 = fe_cnt;
        send_bits(24'hFFFFFF, 7, 4);
        check("pre_reset_oe", outputs_enabled, 1);
        rst = 1'b0;
        #2;
        check_zero("midreset");
        tick(3);
        check("midreset_oe_held", outputs_enabled, 0);
        rst = 1'b1;
        tick(3);
        send_bits(24'h555555, 7, 0);
        check("post_reset_valid", dv_cnt - d0, 1);
        check("post_reset_error", fe_cnt - f0, 0);
        check("post_reset_data", data_out, 24'h555555);
        check("post_reset_wic", words_in_column, 1);
        check("post_reset_oe", outputs_enabled, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
